// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: digit width,
// controller states and the greater/equal/less cascade encoding.
`timescale 1ns/1ps
package seq_mag_comparator_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // EQ is the all-zero code so a cleared register reads as "equal so far".
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_e;

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// One step of the MSB-first compare cascade: folds a single 4-bit digit
// pair into the running greater/equal/less verdict.
`timescale 1ns/1ps
module seq_mag_comparator_digit_cmp
  import seq_mag_comparator_pkg::*;
(
  input  logic [DIGIT_W-1:0] x_i,
  input  logic [DIGIT_W-1:0] y_i,
  input  cmp_e               cas_i,
  output cmp_e               cas_o
);

  // A decided verdict is sticky; only an "equal so far" state looks at the digits.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives the output and no latch is inferred.
    cas_o = cas_i;
    if (cas_i == CMP_EQ) begin
      if (x_i > y_i) begin
        cas_o = CMP_GT;
      end else if (x_i < y_i) begin
        cas_o = CMP_LT;
      end
    end
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator. Accepts an operand pair in
// IDLE, walks one digit per clock MSB first in RUN, then holds a one-hot
// result in DONE until the consumer takes it.
`timescale 1ns/1ps
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NDIG  = WIDTH / DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y_g,
  output logic             y_eq,
  output logic             y_l
);

  localparam int              CNT_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(NDIG - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               signed_q, signed_d;
  cmp_e               cas_q, cas_d;

  logic [DIGIT_W-1:0] dig_a, dig_b;
  cmp_e               cas_nxt;

  // Pick the digit pair addressed by the counter; in signed mode the top
  // digit's sign bit is flipped so two's complement orders as offset binary.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        dig_a = a_q[i*DIGIT_W +: DIGIT_W];
        dig_b = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
    if (signed_q && (cnt_q == CNT_MSB)) begin
      dig_a[DIGIT_W-1] = ~dig_a[DIGIT_W-1];
      dig_b[DIGIT_W-1] = ~dig_b[DIGIT_W-1];
    end
  end

  seq_mag_comparator_digit_cmp u_digit_cmp (
    .x_i   (dig_a),
    .y_i   (dig_b),
    .cas_i (cas_q),
    .cas_o (cas_nxt)
  );

  // Controller next state: accept in IDLE, one digit per edge in RUN, hold in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    cas_d    = cas_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          cas_d    = CMP_EQ;
          cnt_d    = CNT_MSB;
          state_d  = RUN;
        end
      end
      RUN: begin
        cas_d = cas_nxt;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any compare in flight and discards a pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_MSB;
      // NOTE: the operand registers are reset too, so a fresh part never compares X data.
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cas_q    <= CMP_EQ;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      cas_q    <= cas_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y_g       = (cas_q == CMP_GT);
  assign y_eq      = (cas_q == CMP_EQ);
  assign y_l       = (cas_q == CMP_LT);

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: stimulus pushes expected
// {gt,eq,lt} triples computed with plain signed/unsigned arithmetic; a
// separate monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_seq_mag_comparator;

  localparam int W    = 16;
  localparam int NDIG = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic         y_g, y_eq, y_l;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [2:0] exp_q[$];

  seq_mag_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_g       (y_g),
    .y_eq      (y_eq),
    .y_l       (y_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: ordering of the two words as integers of the chosen kind.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic gt, lt;
    if (s) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    return {gt, !(gt || lt), lt};
  endfunction

  // Monitor: every result handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("result_gel", {29'd0, y_g, y_eq, y_l}, {29'd0, e});
        check("result_onehot", $countones({y_g, y_eq, y_l}), 32'd1);
      end
    end
  end

  // Called #1 after a posedge; presents one request and returns #1 after its accept edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("issue_in_ready", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; is_signed = sv; in_valid = 1'b1;
    exp_q.push_back(ref_cmp(av, bv, sv));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Result must appear exactly NDIG edges after the accept edge, not earlier.
  task automatic check_latency();
    repeat (NDIG - 1) @(posedge clk);
    #1 check("latency_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 check("latency_ready", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    issue(av, bv, sv);
    check_latency();
    @(posedge clk); #1;
  endtask

  initial begin
    int last, accepts, k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0;

    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flags", {29'd0, y_g, y_eq, y_l}, 32'b010);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run(16'h1234, 16'h1234, 1'b0);
    run(16'h8000, 16'h7FFF, 1'b0);
    run(16'h8000, 16'h7FFF, 1'b1);
    run(16'hA5F0, 16'hA5F1, 1'b0);
    run(16'hB000, 16'hA999, 1'b0);

    // Backpressure: result holds and new requests are ignored.
    out_ready = 1'b0;
    issue(16'h0005, 16'h0009, 1'b0);
    check_latency();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
      @(posedge clk); #1;
      check("bp_hold_flags", {29'd0, y_g, y_eq, y_l}, 32'b001);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_flags_kept", {29'd0, y_g, y_eq, y_l}, 32'b001);
    run(16'h7000, 16'h6FFF, 1'b1);

    // Asynchronous reset in the middle of RUN.
    issue(16'h0001, 16'h0002, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_flags", {29'd0, y_g, y_eq, y_l}, 32'b010);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run(16'hFFFF, 16'h0001, 1'b1);

    // Back-to-back with in_valid and out_ready held high; operands churn every cycle.
    last = -1; accepts = 0; k = 0;
    a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
    in_valid = 1'b1;
    while (accepts < 40 && k < 400) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_cmp(a, b, is_signed));
        if (last >= 0) check("accept_spacing", 32'(cyc - last), 32'(NDIG + 2));
        last = cyc;
        accepts++;
      end
      @(posedge clk); #1;
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      is_signed = 1'($urandom);
      k++;
    end
    in_valid = 1'b0;
    check("accept_count", 32'(accepts), 32'd40);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle magnitude comparator for wide operands.
- Walks the operands one 4-bit digit per clock, MSB digit first, and carries a greater/equal/less cascade state between digits.
- Sits between operand producers and control logic that needs the ordering of two WIDTH-bit words without a wide combinational compare.
- Valid/ready handshakes on both input and output sides; supports unsigned and two's-complement compares.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 4.
- NDIG, WIDTH/4, number of 4-bit digits (derived; not to be overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept a compare request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y_g  output  1  A > B.
- y_eq  output  1  A == B.
- y_l  output  1  A < B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - y_g = 0, y_eq = 1, y_l = 0; digit counter = NDIG-1; operand registers = 0.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready, register a, b and is_signed.
  - Initialise cascade state to EQ (y_g = 0, y_eq = 1, y_l = 0), set counter to NDIG-1, and go to RUN.
  - in_ready drops the cycle after acceptance.
- RUN:
  - Each edge evaluates digit [4*cnt+3 : 4*cnt].
  - If the cascade state is EQ and the digits differ, state becomes GT or LT according to the digit compare.
  - Once GT or LT is reached, it is sticky for the remainder of the compare.
  - Signed mode: on the MSB digit only, bit 3 of both digits is inverted before comparing (offset-binary); lower digits are always compared unsigned.
  - When cnt == 0, the digit is processed, the state goes to DONE and out_valid = 1. Otherwise cnt decrements.
  - Fixed latency: accept at edge T; digits processed at edges T+1 .. T+NDIG; out_valid is high after edge T+NDIG. No early exit.
- DONE:
  - out_valid = 1; y_g/y_eq/y_l are held stable and are exactly one-hot.
  - in_ready = 0.
  - On an edge with out_ready high, go to IDLE: out_valid = 0, in_ready = 1. Result flags keep their last value.
  - out_ready low holds indefinitely with the result unchanged.
- No overlap: a new request is accepted only in IDLE. Throughput is one compare per NDIG+2 cycles with out_ready tied high.
- Operand inputs are ignored outside the accept edge. Changes to a, b or is_signed during RUN have no effect.
- Reset asserted mid-RUN or in DONE aborts immediately to the reset values. A pending result is discarded.
- y_* are registered outputs with no combinational path from inputs; they are meaningful only while out_valid = 1.

Decomposition:
- Shared package:
  - DIGIT_W = 4.
  - Enumerated state type {IDLE, RUN, DONE}.
  - Cascade encoding type {CMP_EQ, CMP_GT, CMP_LT}.
- Sub-module digit_cmp (combinational):
  - Inputs: 4-bit x, y and a 2-bit cascade code.
  - Output: the next cascade code.
  - Instantiated once and fed by a mux on the counter.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h1234, unsigned -> out_valid after 4 RUN edges; y_eq=1, y_g=0, y_l=0.
- a=16'h8000, b=16'h7FFF, is_signed=0 -> y_g=1; same operands with is_signed=1 -> y_l=1.
- a=16'hA5F0, b=16'hA5F1 (differ in LSB digit only) -> y_l=1. Then a=16'hB000, b=16'hA999 -> y_g=1 (MSB decides; lower digits must not override).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result is stable, in_ready=0, and in_valid pulses are ignored. Release -> IDLE; the next request is accepted.
- Drop rst_n during the second RUN cycle -> outputs go to reset values asynchronously (out_valid=0, in_ready=1, y_eq=1). After release, a fresh compare a=16'hFFFF, b=16'h0001 signed -> y_l=1.
- Back-to-back with in_valid and out_ready held high on random operands -> accept spacing is exactly NDIG+2 cycles; every result matches the reference model for both modes.
